// File: rtl/i2s_stereo_tx_if.sv
// Stereo sample-pair handshake between the gain stage and the I2S serializer.
interface i2s_stereo_tx_if #(
    parameter int unsigned DATA_W = 24
);
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_left;
    logic [DATA_W-1:0] s_right;

    modport master (output s_valid, output s_left, output s_right, input s_ready);
    modport slave  (input s_valid, input s_left, input s_right, output s_ready);
endinterface

// File: rtl/i2s_stereo_tx.sv
// Stereo I2S / left-justified serializer: sample-pair FIFO feeding a frame shift
// register, with bclk/lrclk/sdata generation and a frame_tick at every frame load.
module i2s_stereo_tx #(
    parameter int unsigned DATA_W     = 24,
    parameter int unsigned SLOT_W     = 32,
    parameter int unsigned BCLK_DIV   = 4,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter bit          I2S_MODE   = 1'b1
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          enable,
    input  logic                          mono,
    i2s_stereo_tx_if.slave                s_if,
    input  logic                          underrun_clr,
    output logic                          bclk,
    output logic                          lrclk,
    output logic                          sdata,
    output logic                          frame_tick,
    output logic                          underrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int unsigned FRAME_W = 2 * SLOT_W;
    localparam int unsigned CNT_W   = $clog2(FRAME_W);
    localparam int unsigned PH_W    = $clog2(BCLK_DIV);
    localparam int unsigned HALF    = BCLK_DIV / 2;
    localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W   = PTR_W + 1;
    localparam int unsigned PAIR_W  = 2 * DATA_W;

    typedef enum logic {ST_IDLE, ST_RUN} state_e;

    state_e             state_q, state_d;
    logic [PH_W-1:0]    ph_q, ph_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic               bclk_q, bclk_d;
    logic               lrclk_q, lrclk_d;
    logic               sdata_q, sdata_d;
    logic               tick_q, tick_d;
    logic               underrun_q, underrun_d;
    logic               s_ready_q, s_ready_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PAIR_W-1:0]  mem_q [FIFO_DEPTH];
    logic [PAIR_W-1:0]  mem_d [FIFO_DEPTH];

    logic               push_c, pop_c, load_c, fifo_empty_c;
    logic [DATA_W-1:0]  head_l_c, head_r_c;
    logic [FRAME_W-1:0] frame_new_c;

    // lrclk level for a given bit position; I2S leads the slot MSB by one bclk
    function automatic logic lr_level(input logic [CNT_W-1:0] cnt);
        if (I2S_MODE) begin
            return (32'(cnt) >= SLOT_W - 1) && (32'(cnt) != FRAME_W - 1);
        end
        return 32'(cnt) >= SLOT_W;
    endfunction

    always_comb begin
        state_d    = state_q;
        ph_d       = ph_q;
        bit_cnt_d  = bit_cnt_q;
        frame_d    = frame_q;
        bclk_d     = bclk_q;
        lrclk_d    = lrclk_q;
        sdata_d    = sdata_q;
        tick_d     = 1'b0;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        mem_d      = mem_q;
        load_c     = 1'b0;
        pop_c      = 1'b0;

        push_c       = s_if.s_valid & s_ready_q;
        fifo_empty_c = (level_q == '0);
        head_l_c     = mem_q[rd_ptr_q][PAIR_W-1 -: DATA_W];
        head_r_c     = mono ? head_l_c : mem_q[rd_ptr_q][DATA_W-1:0];
        frame_new_c  = fifo_empty_c ? '0
                     : ((FRAME_W'(head_l_c) << (FRAME_W - DATA_W)) |
                        (FRAME_W'(head_r_c) << (SLOT_W - DATA_W)));

        case (state_q)
            ST_IDLE: begin
                ph_d      = '0;
                bit_cnt_d = '0;
                bclk_d    = 1'b0;
                lrclk_d   = 1'b0;
                sdata_d   = 1'b0;
                load_c    = enable;
            end
            ST_RUN: begin
                if (ph_q == PH_W'(BCLK_DIV - 1)) begin
                    // bclk falling edge: advance one bit or close the frame
                    ph_d   = '0;
                    bclk_d = 1'b0;
                    if (bit_cnt_q == CNT_W'(FRAME_W - 1)) begin
                        if (enable) begin
                            load_c = 1'b1;
                        end else begin
                            state_d   = ST_IDLE;
                            bit_cnt_d = '0;
                            lrclk_d   = 1'b0;
                            sdata_d   = 1'b0;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        frame_d   = {frame_q[FRAME_W-2:0], 1'b0};
                        sdata_d   = frame_q[FRAME_W-2];
                        lrclk_d   = lr_level(bit_cnt_d);
                    end
                end else begin
                    ph_d   = ph_q + PH_W'(1);
                    bclk_d = (32'(ph_d) >= HALF);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (load_c) begin
            state_d   = ST_RUN;
            ph_d      = '0;
            bit_cnt_d = '0;
            bclk_d    = 1'b0;
            tick_d    = 1'b1;
            frame_d   = frame_new_c;
            sdata_d   = frame_new_c[FRAME_W-1];
            lrclk_d   = lr_level('0);
            pop_c     = !fifo_empty_c;
        end

        // setting on an empty load wins over a clear in the same cycle
        underrun_d = (load_c && fifo_empty_c) ? 1'b1 : (underrun_clr ? 1'b0 : underrun_q);

        if (push_c) begin
            mem_d[wr_ptr_q] = {s_if.s_left, s_if.s_right};
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_c, pop_c})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
        s_ready_d = (level_d != LVL_W'(FIFO_DEPTH));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            ph_q       <= '0;
            bit_cnt_q  <= '0;
            frame_q    <= '0;
            bclk_q     <= 1'b0;
            lrclk_q    <= 1'b0;
            sdata_q    <= 1'b0;
            tick_q     <= 1'b0;
            underrun_q <= 1'b0;
            s_ready_q  <= 1'b1;
            level_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            mem_q      <= '{default: '0};
        end else begin
            state_q    <= state_d;
            ph_q       <= ph_d;
            bit_cnt_q  <= bit_cnt_d;
            frame_q    <= frame_d;
            bclk_q     <= bclk_d;
            lrclk_q    <= lrclk_d;
            sdata_q    <= sdata_d;
            tick_q     <= tick_d;
            underrun_q <= underrun_d;
            s_ready_q  <= s_ready_d;
            level_q    <= level_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            mem_q      <= mem_d;
        end
    end

    assign s_if.s_ready = s_ready_q;
    assign bclk         = bclk_q;
    assign lrclk        = lrclk_q;
    assign sdata        = sdata_q;
    assign frame_tick   = tick_q;
    assign underrun     = underrun_q;
    assign fifo_level   = level_q;

endmodule
